// File: rtl/norm_shift_64.sv
// norm_shift_64: two-stage normalizer; shifts the mantissa until bit 63 is set and lowers the exponent to match.
// Build option NORM_UNDERFLOW_EN limits the shift to the exponent and flags a denormal result.

module norm_shift_64 #(
   parameter int EXP_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [63:0]          in_mant,
   input  logic [EXP_WIDTH-1:0] in_exp,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          out_mant,
   output logic [EXP_WIDTH-1:0] out_exp,
   output logic                 out_zero,
   output logic                 out_underflow
);

   logic                 s1_v, s2_v;
   logic                 adv1, adv2;
   logic [63:0]          s1_mant;
   logic [EXP_WIDTH-1:0] s1_exp;
   logic [6:0]           s1_lzc;
   logic                 s1_zero;
   logic [6:0]           lzc;
   logic                 lzc_zero;
   logic [EXP_WIDTH-1:0] lzc_ext;
   logic [6:0]           shamt;
   logic [63:0]          nxt_mant;
   logic [EXP_WIDTH-1:0] nxt_exp;
   logic                 nxt_uf;

   LZC_64 u_lzc (
      .data     (in_mant),
      .zero_num (lzc),
      .is_zero  (lzc_zero)
   );

   // A stage may advance when it is empty or the stage after it is advancing.
   assign adv2      = !s2_v || out_ready;
   assign adv1      = !s1_v || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_v;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         s1_v <= 1'b0;
      else if (adv1)
         s1_v <= in_valid;
   end

   // NOTE: payload registers are qualified by s1_v, so they carry no reset.
   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         s1_mant <= in_mant;
         s1_exp  <= in_exp;
         s1_lzc  <= lzc;
         s1_zero <= lzc_zero;
      end
   end

   assign lzc_ext = EXP_WIDTH'(s1_lzc);

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      shamt   = s1_lzc;
      nxt_exp = s1_exp - lzc_ext;
      nxt_uf  = 1'b0;
`ifdef NORM_UNDERFLOW_EN
      if (s1_exp < lzc_ext) begin
         shamt   = 7'(s1_exp);
         nxt_exp = '0;
         nxt_uf  = 1'b1;
      end
`endif
      nxt_mant = s1_mant << shamt;
      if (s1_zero) begin
         nxt_mant = '0;
         nxt_exp  = '0;
         nxt_uf   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v          <= 1'b0;
         out_mant      <= '0;
         out_exp       <= '0;
         out_zero      <= 1'b0;
         out_underflow <= 1'b0;
      end else if (adv2) begin
         s2_v <= s1_v;
         if (s1_v) begin
            out_mant      <= nxt_mant;
            out_exp       <= nxt_exp;
            out_zero      <= s1_zero;
            out_underflow <= nxt_uf;
         end
      end
   end

endmodule

// Leading-zero counter: zero_num is 64 for an all-zero word.
module LZC_64 (
   input  logic [63:0] data,
   output logic [6:0]  zero_num,
   output logic        is_zero
);

   always_comb begin
      zero_num = 7'd64;
      for (int i = 0; i < 64; i++) begin
         if (data[i]) zero_num = 7'(63 - i);
      end
   end

   assign is_zero = (data == 64'd0);

endmodule

// File: tb/tb_norm_shift_64.sv
// tb_norm_shift_64: directed and randomized checks of norm_shift_64 against a behavioural model.
// Expectations follow the build option NORM_UNDERFLOW_EN when it is defined.

module tb_norm_shift_64;

   localparam int EW = 12;

   typedef struct packed {
      logic [63:0]   mant;
      logic [EW-1:0] exp;
      logic          zero;
      logic          uf;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_mant;
   logic [EW-1:0] in_exp;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_mant;
   logic [EW-1:0] out_exp;
   logic          out_zero;
   logic          out_underflow;

   int   compared   = 0;
   int   mismatched = 0;
   int   out_count  = 0;
   res_t exp_q[$];
   logic held_v     = 1'b0;
   res_t held;

   norm_shift_64 #(.EXP_WIDTH(EW)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_mant       (in_mant),
      .in_exp        (in_exp),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_mant      (out_mant),
      .out_exp       (out_exp),
      .out_zero      (out_zero),
      .out_underflow (out_underflow)
   );

   always #5 clk = ~clk;

   // Reference: normalize by doubling until the top bit is set, counting the steps.
   function automatic res_t ref_norm(logic [63:0] m, logic [EW-1:0] e);
      res_t        r;
      int          n;
      logic [63:0] t;
      r = '0;
      if (m == 64'd0) begin
         r.zero = 1'b1;
         return r;
      end
      n = 0;
      t = m;
      while (t[63] == 1'b0) begin
         t = t << 1;
         n++;
      end
`ifdef NORM_UNDERFLOW_EN
      if (int'(e) < n) begin
         r.mant = m << e;
         r.uf   = 1'b1;
         return r;
      end
`endif
      r.mant = t;
      r.exp  = e - EW'(n);
      return r;
   endfunction

   // Scoreboard: record accepted inputs, compare emitted outputs in order, check stalled outputs hold.
   always @(negedge clk) begin
      res_t act;
      res_t want;
      act = {out_mant, out_exp, out_zero, out_underflow};
      if (rst) begin
         exp_q.delete();
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            compared++;
            if (out_valid !== 1'b1 || act !== held) begin
               mismatched++;
               $display("FAIL hold_stable: got v=%b %h want v=1 %h", out_valid, act, held);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            compared++;
            out_count++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL out_unexpected: got %h want no output", act);
            end else begin
               want = exp_q.pop_front();
               if (act !== want) begin
                  mismatched++;
                  $display("FAIL out_data: got %h want %h", act, want);
               end
            end
            held_v = 1'b0;
         end else if (out_valid === 1'b1) begin
            held_v = 1'b1;
            held   = act;
         end else begin
            held_v = 1'b0;
         end
         if (in_valid === 1'b1 && in_ready === 1'b1)
            exp_q.push_back(ref_norm(in_mant, in_exp));
      end
   end

   task automatic rand_in();
      logic [63:0] m;
      int          sh;
      sh      = $urandom_range(0, 64);
      m       = {$urandom, $urandom};
      in_mant = (sh == 64) ? 64'd0 : (m >> sh);
      in_exp  = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 70)) : EW'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mant   = '0;
      in_exp    = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      compared++;
      if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got v=%b %h %h %b %b want all zero",
                  out_valid, out_mant, out_exp, out_zero, out_underflow);
      end
      compared++;
      if (in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [63:0]   vm[4];
      logic [EW-1:0] ve[4];
      res_t          vx[4];
      res_t          act;
      vm[0] = 64'h1;                   ve[0] = 12'd100;
      vx[0] = {64'h8000_0000_0000_0000, 12'd37, 1'b0, 1'b0};
      vm[1] = 64'h0;                   ve[1] = 12'd55;
      vx[1] = {64'h0, 12'd0, 1'b1, 1'b0};
      vm[2] = 64'h0000_0001_0000_0000; ve[2] = 12'd10;
`ifdef NORM_UNDERFLOW_EN
      vx[2] = {64'h0000_0400_0000_0000, 12'd0, 1'b0, 1'b1};
`else
      vx[2] = {64'h8000_0000_0000_0000, 12'hFEB, 1'b0, 1'b0};
`endif
      vm[3] = 64'h8000_0000_0000_0000; ve[3] = 12'd5;
      vx[3] = {64'h8000_0000_0000_0000, 12'd5, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 in_valid = 1'b1;
         in_mant = vm[i];
         in_exp  = ve[i];
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         compared++;
         if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL dir%0d_early: got out_valid %b want 0", i, out_valid);
         end
         @(negedge clk);
         act = {out_mant, out_exp, out_zero, out_underflow};
         compared++;
         if (out_valid !== 1'b1 || act !== vx[i]) begin
            mismatched++;
            $display("FAIL dir%0d_result: got v=%b %h want v=1 %h", i, out_valid, act, vx[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int   accepted = 0;
      logic fire;
      @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b1;
      rand_in();
      for (int c = 0; c < 40 && accepted < 4; c++) begin
         @(negedge clk);
         fire = in_valid && in_ready;
         if (c == 2) begin
            compared++;
            if (in_ready !== 1'b0 || accepted != 2) begin
               mismatched++;
               $display("FAIL bp_full: got in_ready=%b accepted=%0d want 0 and 2", in_ready, accepted);
            end
         end
         if (fire) accepted++;
         @(posedge clk);
         #1;
         if (c == 2) out_ready = 1'b1;
         if (fire) begin
            if (accepted < 4) rand_in();
            else in_valid = 1'b0;
         end
      end
      compared++;
      if (accepted != 4) begin
         mismatched++;
         $display("FAIL bp_accepted: got %0d want 4", accepted);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int base;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1 in_valid = 1'b1;
         rand_in();
         @(negedge clk);
         compared++;
         if (in_ready !== 1'b1 || (i >= 2 && out_valid !== 1'b1)) begin
            mismatched++;
            $display("FAIL b2b_bubble%0d: got in_ready=%b out_valid=%b want 1 and 1", i, in_ready, out_valid);
         end
      end
      @(posedge clk);
      #1 rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_flush: got out_valid %b want 0", out_valid);
      end
      base = out_count;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 in_valid = 1'b1;
         rand_in();
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();
      compared++;
      if (out_count - base != 5) begin
         mismatched++;
         $display("FAIL rst_post_count: got %0d want 5", out_count - base);
      end
   endtask

   task automatic test_random();
      int   base;
      int   accepted = 0;
      logic fire;
      base = out_count;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         fire = in_valid && in_ready;
         if (fire) accepted++;
         @(posedge clk);
         #1;
         if (!in_valid || fire) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_in();
         end
         out_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      compared++;
      if (out_count - base != accepted) begin
         mismatched++;
         $display("FAIL rand_count: got %0d outputs want %0d", out_count - base, accepted);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
